imem_load_arbiter: RTL and testbench

IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_load_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_load_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
package imem_pkg;

  localparam int          IMEM_DEPTH  = 128;
  localparam int          IMEM_ADDR_W = 7;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_load_arbiter.sv
// Instruction memory load arbiter: shares one external memory port between a
// boot loader (write) and the instruction fetch path (read), holding fetch
// until an image is loaded or fetch is released directly.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to build the XOR checksum of
// accepted loader words; otherwise load_csum is tied to zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, fetch stalled, waiting for load_start or run_en
// LOAD  | accepting loader words, writing them to sequential addresses
// DONE  | one-cycle load_done pulse, fetch still stalled
// RUN   | fetch owns the memory; load_start triggers a reload
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              run_en,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic [31:0]       load_csum,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_data,
  output logic              fetch_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  // Count value held by the beat that fills the memory; the load ends there
  // so the counter never wraps.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  imem_state_e       state_q;
  imem_state_e       state_d;
  logic [ADDR_W:0]   count_d;

  // Next state, next count and all outputs decoded from the registered state.
  always_comb begin
    state_d    = state_q;
    count_d    = load_count;
    load_ready = 1'b0;
    load_done  = 1'b0;
    fetch_hold = 1'b1;
    fetch_data = NOP_WORD;
    mem_addr   = fetch_addr;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
        end else if (run_en) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_addr   = load_count[ADDR_W-1:0];
        mem_wdata  = load_data;
        mem_we     = load_valid;
        if (load_valid) begin
          count_d = load_count + CNT_ONE;
          if (load_last || (load_count == CNT_LAST)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        fetch_hold = 1'b0;
        fetch_data = mem_rdata;
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and load counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      load_count <= '0;
    end else begin
      state_q    <= state_d;
      load_count <= count_d;
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic        csum_clr;
  logic        csum_acc;
  logic [31:0] csum_q;

  assign csum_clr = load_start && ((state_q == IDLE) || (state_q == RUN));
  assign csum_acc = load_ready && load_valid;

  // Running XOR of accepted words; cleared when a load is started and held
  // afterwards so software can read it back in RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (csum_clr) begin
      csum_q <= '0;
    end else if (csum_acc) begin
      csum_q <= csum_q ^ load_data;
    end
  end

  assign load_csum = csum_q;
`else
  assign load_csum = '0;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter with a behavioural memory and a
// write scoreboard.
module tb_imem_load_arbiter;

  logic        clock;
  logic        reset;
  logic        load_start;
  logic        run_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  load_count;
  logic [31:0] load_csum;
  logic [6:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_hold;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  wr_t         w_exp;
  logic [31:0] mem_model [0:127];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          done_cnt = 0;
  int          exp_addr = 0;
  logic [31:0] exp_csum = '0;

  imem_load_arbiter #(.DEPTH(128), .ADDR_W(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .run_en     (run_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .load_csum  (load_csum),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_hold (fetch_hold),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural synchronous-write, asynchronous-read memory.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mem_model[i] <= 32'hCAFE_0000 | 32'(i);
    end else if (mem_we === 1'b1) begin
      mem_model[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_model[mem_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] csum_exp();
`ifdef IMEM_LOAD_CHECKSUM_EN
    return exp_csum;
`else
    return 32'h0;
`endif
  endfunction

  // Write scoreboard and load_done pulse counter, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        check_val("spurious_we", 32'(mem_we), 32'h0);
      end else begin
        w_exp = wq.pop_front();
        check_val("wr_addr", 32'(mem_addr), 32'(w_exp.addr));
        check_val("wr_data", mem_wdata, w_exp.data);
      end
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    load_valid = v;
    load_data  = d;
    load_last  = l;
    if (v) begin
      wq.push_back('{addr: 7'(exp_addr), data: d});
      exp_addr++;
      exp_csum ^= d;
    end
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
  endtask

  task automatic begin_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    exp_addr   = 0;
    exp_csum   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    run_en     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    fetch_addr = '0;
    repeat (3) step();

    // Reset state
    check_val("rst_ready", 32'(load_ready), 32'h0);
    check_val("rst_hold",  32'(fetch_hold), 32'h1);
    check_val("rst_count", 32'(load_count), 32'h0);
    check_val("rst_csum",  load_csum,       32'h0);
    check_val("rst_done",  32'(load_done),  32'h0);
    check_val("rst_we",    32'(mem_we),     32'h0);
    check_val("rst_fdata", fetch_data,      32'h0);
    reset = 1'b1;

    // Release fetch without loading
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    check_val("run_hold", 32'(fetch_hold), 32'h0);
    fetch_addr = 7'd5;
    #1;
    check_val("run_fdata5", fetch_data, 32'hCAFE_0005);
    check_val("run_maddr", 32'(mem_addr), 32'h5);
    fetch_addr = 7'd9;
    #1;
    check_val("run_fdata9", fetch_data, 32'hCAFE_0009);

    // Reload from RUN with a four-word image
    begin_load();
    check_val("l4_hold",  32'(fetch_hold), 32'h1);
    check_val("l4_ready", 32'(load_ready), 32'h1);
    check_val("l4_count0", 32'(load_count), 32'h0);
    check_val("l4_fnop",  fetch_data,      32'h0);
    beat(1'b1, 32'h11, 1'b0);
    beat(1'b1, 32'h22, 1'b0);
    beat(1'b1, 32'h33, 1'b0);
    beat(1'b1, 32'h44, 1'b1);
    check_val("l4_done",  32'(load_done),  32'h1);
    check_val("l4_count", 32'(load_count), 32'h4);
    check_val("l4_ready_done", 32'(load_ready), 32'h0);
    check_val("l4_hold_done",  32'(fetch_hold), 32'h1);
    step();
    check_val("l4_done_off", 32'(load_done), 32'h0);
    check_val("l4_run_hold", 32'(fetch_hold), 32'h0);
    check_val("l4_csum", load_csum, csum_exp());
    check_val("l4_csum_lit", load_csum, csum_exp() & 32'h44);
    check_val("l4_done_cnt", 32'(done_cnt), 32'h1);
    check_val("l4_wq_empty", 32'(wq.size()), 32'h0);
    fetch_addr = 7'd2;
    #1;
    check_val("l4_fetch_loaded", fetch_data, 32'h33);

    // Gapped valid: only accepted beats write, addresses stay contiguous
    begin_load();
    beat(1'b1, 32'hA000_0001, 1'b0);
    beat(1'b0, 32'hBAD0_0000, 1'b0);
    beat(1'b1, 32'hA000_0002, 1'b0);
    beat(1'b0, 32'hBAD0_0001, 1'b0);
    check_val("gap_count", 32'(load_count), 32'h2);
    check_val("gap_ready", 32'(load_ready), 32'h1);
    beat(1'b1, 32'hA000_0003, 1'b1);
    check_val("gap_done",  32'(load_done),  32'h1);
    check_val("gap_count_end", 32'(load_count), 32'h3);
    step();
    check_val("gap_csum", load_csum, csum_exp());
    check_val("gap_done_cnt", 32'(done_cnt), 32'h2);
    check_val("gap_wq_empty", 32'(wq.size()), 32'h0);

    // From IDLE, load_start beats run_en; reset abandons the load
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_val("idle_hold", 32'(fetch_hold), 32'h1);
    load_start = 1'b1;
    run_en     = 1'b1;
    step();
    load_start = 1'b0;
    run_en     = 1'b0;
    exp_addr   = 0;
    exp_csum   = '0;
    check_val("both_ready", 32'(load_ready), 32'h1);
    check_val("both_hold",  32'(fetch_hold), 32'h1);
    beat(1'b1, 32'h5555_0000, 1'b0);
    load_start = 1'b1;
    beat(1'b1, 32'h5555_0001, 1'b0);
    load_start = 1'b0;
    beat(1'b1, 32'h5555_0002, 1'b0);
    check_val("abort_count_pre", 32'(load_count), 32'h3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_val("abort_count", 32'(load_count), 32'h0);
    check_val("abort_hold",  32'(fetch_hold), 32'h1);
    check_val("abort_ready", 32'(load_ready), 32'h0);
    check_val("abort_done",  32'(load_done),  32'h0);
    check_val("abort_csum",  load_csum,       32'h0);
    step();
    check_val("abort_done_cnt", 32'(done_cnt), 32'h2);
    check_val("abort_idle_hold", 32'(fetch_hold), 32'h1);
    check_val("abort_wq_empty", 32'(wq.size()), 32'h0);

    // Full-depth load with no last flag
    begin_load();
    for (int i = 0; i < 128; i++) beat(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
    check_val("full_count", 32'(load_count), 32'h80);
    check_val("full_done",  32'(load_done),  32'h1);
    check_val("full_ready", 32'(load_ready), 32'h0);
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_val("full_run_hold", 32'(fetch_hold), 32'h0);
    check_val("full_run_ready", 32'(load_ready), 32'h0);
    check_val("full_run_count", 32'(load_count), 32'h80);
    check_val("full_csum", load_csum, csum_exp());
    step();
    load_valid = 1'b0;
    load_data  = '0;
    check_val("full_count_hold", 32'(load_count), 32'h80);
    check_val("full_done_cnt", 32'(done_cnt), 32'h3);
    check_val("full_wq_empty", 32'(wq.size()), 32'h0);
    fetch_addr = 7'd127;
    #1;
    check_val("full_fetch127", fetch_data, 32'h1000_007F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
